// File: rtl/codec_cfg_pkg.sv
// Shared types and constants for the WM8731 configuration sequencer:
// FSM state encoding, codec register addresses and the default init table.
package codec_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_SETTLE,
        ST_DONE,
        ST_FAIL
    } cfg_state_e;

    localparam int CFG_NUM_REGS = 9;

    // WM8731 register addresses (7-bit, occupy word bits 15:9)
    localparam logic [6:0] REG_LEFT_HP  = 7'h02;
    localparam logic [6:0] REG_RIGHT_HP = 7'h03;
    localparam logic [6:0] REG_ANALOG   = 7'h04;
    localparam logic [6:0] REG_DIGITAL  = 7'h05;
    localparam logic [6:0] REG_POWER    = 7'h06;
    localparam logic [6:0] REG_IFACE    = 7'h07;
    localparam logic [6:0] REG_SAMPLING = 7'h08;
    localparam logic [6:0] REG_ACTIVE   = 7'h09;
    localparam logic [6:0] REG_RESET    = 7'h0F;

    localparam logic [15:0] WORD_RESET    = {REG_RESET,    9'h000};
    localparam logic [15:0] WORD_POWER    = {REG_POWER,    9'h000};
    localparam logic [15:0] WORD_ANALOG   = {REG_ANALOG,   9'h012};
    localparam logic [15:0] WORD_DIGITAL  = {REG_DIGITAL,  9'h000};
    localparam logic [15:0] WORD_IFACE    = {REG_IFACE,    9'h023};
    localparam logic [15:0] WORD_SAMPLING = {REG_SAMPLING, 9'h02F};
    localparam logic [15:0] WORD_LEFT_HP  = {REG_LEFT_HP,  9'h060};
    localparam logic [15:0] WORD_RIGHT_HP = {REG_RIGHT_HP, 9'h060};
    localparam logic [15:0] WORD_ACTIVE   = {REG_ACTIVE,   9'h001};

endpackage

// File: rtl/codec_cfg_rom.sv
// Combinational index-to-word lookup for the codec init table; edit here
// to change register contents without touching the sequencer FSM.
module codec_cfg_rom
    import codec_cfg_pkg::*;
(
    input  logic [3:0]  index,
    output logic [15:0] word
);

    always_comb begin
        word = '0;
        case (index)
            4'd0: word = WORD_RESET;
            4'd1: word = WORD_POWER;
            4'd2: word = WORD_ANALOG;
            4'd3: word = WORD_DIGITAL;
            4'd4: word = WORD_IFACE;
            4'd5: word = WORD_SAMPLING;
            4'd6: word = WORD_LEFT_HP;
            4'd7: word = WORD_RIGHT_HP;
            4'd8: word = WORD_ACTIVE;
            default: word = '0;
        endcase
    end

endmodule

// File: rtl/codec_config_sequencer.sv
// Walks the WM8731 init table over the I2C command master, retrying NACKed
// words, and enables audio streaming once every word has been acknowledged.
module codec_config_sequencer
    import codec_cfg_pkg::*;
#(
    parameter int NUM_REGS      = CFG_NUM_REGS,
    parameter int MAX_RETRY     = 3,
    parameter int SETTLE_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        irstn,
    input  logic        start,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [15:0] cmd_word,
    input  logic        xfer_done,
    input  logic        xfer_ack,
    output logic        busy,
    output logic        cfg_done,
    output logic        cfg_error,
    output logic [3:0]  err_index,
    output logic        stream_en
);

    localparam int RETRY_W  = $clog2(MAX_RETRY + 1);
    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [3:0]          LAST_INDEX  = 4'(NUM_REGS - 1);
    localparam logic [RETRY_W-1:0]  LAST_RETRY  = RETRY_W'(MAX_RETRY - 1);
    localparam logic [SETTLE_W-1:0] LAST_SETTLE = SETTLE_W'(SETTLE_CYCLES - 1);

    cfg_state_e          state, state_next;
    logic [3:0]          index, index_next;
    logic [RETRY_W-1:0]  retry, retry_next;
    logic [SETTLE_W-1:0] settle_cnt, settle_next;
    logic [3:0]          err_next;
    logic [15:0]         rom_word;

    codec_cfg_rom u_rom (
        .index (index),
        .word  (rom_word)
    );

    always_ff @(posedge clk or negedge irstn) begin
        if (!irstn) begin
            state      <= ST_IDLE;
            index      <= '0;
            retry      <= '0;
            settle_cnt <= '0;
            err_index  <= '0;
        end else begin
            state      <= state_next;
            index      <= index_next;
            retry      <= retry_next;
            settle_cnt <= settle_next;
            err_index  <= err_next;
        end
    end

    always_comb begin
        state_next  = state;
        index_next  = index;
        retry_next  = retry;
        settle_next = settle_cnt;
        err_next    = err_index;
        cmd_valid   = 1'b0;
        cmd_word    = '0;
        busy        = 1'b0;
        cfg_done    = 1'b0;
        cfg_error   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    index_next = '0;
                    retry_next = '0;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cmd_valid = 1'b1;
                cmd_word  = rom_word;
                busy      = 1'b1;
                if (cmd_ready) state_next = ST_WAIT;
            end
            ST_WAIT: begin
                busy = 1'b1;
                if (xfer_done) begin
                    if (xfer_ack) begin
                        retry_next = '0;
                        if (index == 4'd0) begin
                            // codec needs idle time after its soft reset
                            settle_next = '0;
                            state_next  = ST_SETTLE;
                        end else if (index == LAST_INDEX) begin
                            state_next = ST_DONE;
                        end else begin
                            index_next = index + 4'd1;
                            state_next = ST_ISSUE;
                        end
                    end else if (retry == LAST_RETRY) begin
                        err_next   = index;
                        state_next = ST_FAIL;
                    end else begin
                        retry_next = retry + RETRY_W'(1);
                        state_next = ST_ISSUE;
                    end
                end
            end
            ST_SETTLE: begin
                busy = 1'b1;
                if (settle_cnt == LAST_SETTLE) begin
                    index_next = 4'd1;
                    state_next = ST_ISSUE;
                end else begin
                    settle_next = settle_cnt + SETTLE_W'(1);
                end
            end
            ST_DONE, ST_FAIL: begin
                cfg_done  = (state == ST_DONE);
                cfg_error = (state == ST_FAIL);
                if (start) begin
                    err_next   = '0;
                    index_next = '0;
                    retry_next = '0;
                    state_next = ST_ISSUE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign stream_en = cfg_done;

endmodule

// File: doc/codec_config_sequencer.md
# codec_config_sequencer

Sequences the WM8731 register-initialisation writes over the shared I2C command master and gates audio playback until configuration is complete. Walks a fixed 9-entry table of 16-bit words (bits 15:9 register address, bits 8:0 data), issues each word through a valid/ready handshake, and retries NACKed words. Sits between top-level control (KEY/SW start) and the I2C protocol engine. Raises `stream_en` to the ROM/DAC playback logic once every word is acknowledged.

## Interface
Parameters:
- `NUM_REGS`, 9: number of table entries issued.
- `MAX_RETRY`, 3: attempts per word before failure (≥1).
- `SETTLE_CYCLES`, 1024: idle clk cycles inserted after the reset word (index 0).

Ports:
- `clk`  in  1  system clock (50 MHz); sole clock.
- `irstn`  in  1  reset; asynchronous and active-low.
- `start`  in  1  level/pulse request to (re)run configuration.
- `cmd_valid`  out  1  word on `cmd_word` offered to I2C master.
- `cmd_ready`  in  1  master can accept a word.
- `cmd_word`  out  16  register word being offered.
- `xfer_done`  in  1  one-cycle pulse: master finished a transfer.
- `xfer_ack`  in  1  qualified by `xfer_done`; 1 = all three ACK slots received.
- `busy`  out  1  sequence in progress.
- `cfg_done`  out  1  all words acknowledged (level).
- `cfg_error`  out  1  a word exhausted its retries (level).
- `err_index`  out  4  table index that failed.
- `stream_en`  out  1  playback enable; equals `cfg_done`.

## Operation
- States: IDLE, ISSUE, WAIT, SETTLE, DONE, FAIL.
- Table order (index: word): 0 `1E00` reset, 1 `0C00` power, 2 `0812` analog path, 3 `0A00` digital path, 4 `0E23` interface format, 5 `102F` sampling, 6 `0460` left HP, 7 `0660` right HP, 8 `1201` activate.
- IDLE: `start`=1 → index←0, retry←0, → ISSUE.
- ISSUE: `cmd_valid`=1, `cmd_word`=table[index], both held stable until `cmd_valid && cmd_ready` (transfer) → WAIT.
- WAIT: on `xfer_done`:
  - `xfer_ack`=1: retry←0; index 0 → SETTLE; index `NUM_REGS-1` → DONE; else index+1 → ISSUE.
  - `xfer_ack`=0: retry+1 == `MAX_RETRY` → FAIL with `err_index`←index; else retry+1, → ISSUE with same index.
- SETTLE: count `SETTLE_CYCLES` cycles, then index←1 → ISSUE.
- DONE: `cfg_done`=`stream_en`=1. FAIL: `cfg_error`=1, `err_index` held.
- DONE/FAIL + `start`=1 → clears `cfg_done`/`cfg_error`/`err_index`, index←0 → ISSUE (full rerun).
- `start` in ISSUE/WAIT/SETTLE ignored. `xfer_done` outside WAIT ignored.
- Retry counter width $clog2(MAX_RETRY+1); index 4 bits, never exceeds `NUM_REGS-1`.

## Timing
- Reset (async assert, sync release): state IDLE; all outputs 0, `cmd_word`=0.
- `start` high at edge N in IDLE → `cmd_valid`=1 with `1E00` after edge N, `busy`=1 same cycle.
- Handshake at edge M → `cmd_valid`=0 after M.
- `xfer_done`+ack at edge K (index≥1, not last) → `cmd_valid`=1 with next word after K (one-cycle turnaround).
- Reset word ack at K → `cmd_valid` for index 1 rises after edge K+`SETTLE_CYCLES`.
- Last ack at K → `cfg_done`, `stream_en`=1, `busy`=0 after K.
- `xfer_done` and `cmd_ready` in the same cycle: only the state-relevant one acts.
- `irstn` low mid-transfer: immediate abort to IDLE; no output recovery beyond reset values.

## Structure
- Shared package `codec_cfg_pkg`: state enum, WM8731 register-address constants, default table words, `NUM_REGS` default.
- Sub-module `codec_cfg_rom`: combinational index→word lookup, so table contents change without touching the FSM.
- FSM, retry counter, settle counter in the top module.

## Test plan
- Always-ACK master, `cmd_ready` tied 1, `SETTLE_CYCLES`=4: pulse `start` → 9 words in table order `1E00`…`1201`, 4-cycle gap after first ack, `cfg_done`=`stream_en`=1, `busy`=0.
- `cmd_ready` low 5 cycles on word 3 → `cmd_word`=`0A00` stable with `cmd_valid` high throughout; sequence continues unchanged.
- NACK word 5 twice then ACK → `102F` issued 3 times, `cfg_done`=1, `cfg_error`=0.
- NACK word 6 always, `MAX_RETRY`=3 → `0460` issued 3 times, `cfg_error`=1, `err_index`=6, `stream_en`=0; `start` → rerun from `1E00` with flags cleared.
- Assert `irstn` low while in WAIT on word 4 → all outputs 0 immediately; `start` after release restarts at `1E00`.
- Spurious `xfer_done` in IDLE and `start` during WAIT → no state change, no extra words.
